clock_set_ctrl: RTL and testbench

Consumes the four one-cycle key press pulses from the key debounce stage and drives a 24-hour HH:MM:SS clock with key-driven time setting. It sits between key debouncing and the display/segment driver. It holds the running time, generates the 1 s tick, and runs the mode FSM for setting hours, minutes and seconds. It also supplies a blink flag for the field being edited.

---
 rtl/clock_set_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// 24-hour HH:MM:SS clock with key-driven time setting, 1 s tick generation
// and a blink flag for the field being edited.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_pulse,
    output logic [1:0] mode,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       blink,
    output logic       sec_tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] presc, presc_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [4:0]    hour_nxt;
    logic [5:0]    minute_nxt, second_nxt, field_ed;
    logic          blink_nxt, tick_nxt, advance;
    logic          key_mode, key_clr, key_inc, key_dec, key_edit, wrap;

    function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] last);
        return (v >= last) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] step_dn(input logic [5:0] v, input logic [5:0] last);
        return (v == 6'd0) ? last : v - 6'd1;
    endfunction

    // Caller guarantees one of CLR/INC/DEC is active; DEC is the fall-through.
    function automatic logic [5:0] edit_field(input logic [5:0] v, input logic [5:0] last,
                                              input logic clr, input logic inc);
        if (clr)
            return 6'd0;
        else if (inc)
            return step_up(v, last);
        else
            return step_dn(v, last);
    endfunction

    // Priority MODE > CLR > INC > DEC: lower bits are masked by any higher one.
    assign key_mode = key_pulse[0];
    assign key_clr  = key_pulse[3] & ~key_pulse[0];
    assign key_inc  = key_pulse[1] & ~key_pulse[0] & ~key_pulse[3];
    assign key_dec  = key_pulse[2] & ~key_pulse[0] & ~key_pulse[3] & ~key_pulse[1];
    assign key_edit = key_clr | key_inc | key_dec;
    assign wrap     = (presc == TICK_LAST);
    assign mode     = state;

    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        bcnt_nxt   = bcnt;
        hour_nxt   = hour;
        minute_nxt = minute;
        second_nxt = second;
        blink_nxt  = blink;
        tick_nxt   = 1'b0;
        advance    = 1'b0;
        field_ed   = 6'd0;

        if (state == RUN) begin
            blink_nxt = 1'b1;
            bcnt_nxt  = '0;
            if (key_clr) begin
                second_nxt = 6'd0;
                presc_nxt  = '0;
            end else if (wrap) begin
                presc_nxt = '0;
                advance   = 1'b1;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end else begin
            presc_nxt = '0;
            if (key_edit) begin
                bcnt_nxt  = '0;
                blink_nxt = 1'b1;
                case (state)
                    SET_H: begin
                        field_ed = edit_field({1'b0, hour}, 6'd23, key_clr, key_inc);
                        hour_nxt = field_ed[4:0];
                    end
                    SET_M: begin
                        field_ed   = edit_field(minute, 6'd59, key_clr, key_inc);
                        minute_nxt = field_ed;
                    end
                    default: begin
                        field_ed   = edit_field(second, 6'd59, key_clr, key_inc);
                        second_nxt = field_ed;
                    end
                endcase
            end else if (bcnt == BLINK_LAST) begin
                bcnt_nxt  = '0;
                blink_nxt = ~blink;
            end else begin
                bcnt_nxt = bcnt + 1'b1;
            end
        end

        // Carry chain; also taken when MODE lands on a wrap.
        if (advance) begin
            tick_nxt   = 1'b1;
            second_nxt = step_up(second, 6'd59);
            if (second == 6'd59) begin
                minute_nxt = step_up(minute, 6'd59);
                if (minute == 6'd59)
                    hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
        end

        if (key_mode) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                default: state_nxt = RUN;
            endcase
            presc_nxt = '0;
            bcnt_nxt  = '0;
            blink_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            presc    <= '0;
            bcnt     <= '0;
            hour     <= 5'd0;
            minute   <= 6'd0;
            second   <= 6'd0;
            blink    <= 1'b1;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            bcnt     <= bcnt_nxt;
            hour     <= hour_nxt;
            minute   <= minute_nxt;
            second   <= second_nxt;
            blink    <= blink_nxt;
            sec_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: time-of-day model in total seconds checked every
// cycle, plus directed key sequences with hand-computed expectations.
module tb_clock_set_ctrl;

    localparam int TD = 10;
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_pulse = 4'b0;
    logic [1:0] mode;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic       blink, sec_tick;

    localparam logic [3:0] K_MODE = 4'b0001;
    localparam logic [3:0] K_INC  = 4'b0010;
    localparam logic [3:0] K_DEC  = 4'b0100;
    localparam logic [3:0] K_CLR  = 4'b1000;

    clock_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .mode(mode), .hour(hour),
        .minute(minute), .second(second), .blink(blink), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the clock is a count of seconds since midnight.
    int m_mode = 0, m_t = 0, m_pre = 0, m_bc = 0;
    bit m_blink = 1'b1, m_tick = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_pre = 0; m_bc = 0; m_blink = 1'b1; m_tick = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] k);
        int h, mi, s, f, lim;
        m_tick = 1'b0;
        if (k[0]) begin
            if (m_mode == 0 && m_pre == TD - 1) begin
                m_t = (m_t + 1) % 86400;
                m_tick = 1'b1;
            end
            m_mode = (m_mode + 1) % 4;
            m_pre = 0; m_bc = 0; m_blink = 1'b1;
        end else if (m_mode == 0) begin
            if (k[3]) begin
                m_t = m_t - (m_t % 60);
                m_pre = 0;
            end else if (m_pre == TD - 1) begin
                m_pre = 0;
                m_t = (m_t + 1) % 86400;
                m_tick = 1'b1;
            end else begin
                m_pre++;
            end
        end else if (k[3] || k[1] || k[2]) begin
            h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
            lim = (m_mode == 1) ? 24 : 60;
            f = (m_mode == 1) ? h : (m_mode == 2) ? mi : s;
            if (k[3]) f = 0;
            else if (k[1]) f = (f + 1) % lim;
            else f = (f + lim - 1) % lim;
            if (m_mode == 1) h = f; else if (m_mode == 2) mi = f; else s = f;
            m_t = h * 3600 + mi * 60 + s;
            m_bc = 0; m_blink = 1'b1;
        end else if (m_bc == BD - 1) begin
            m_bc = 0; m_blink = !m_blink;
        end else begin
            m_bc++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(key_pulse);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_mode", mode, m_mode);
            check("cyc_hour", hour, m_t / 3600);
            check("cyc_minute", minute, (m_t / 60) % 60);
            check("cyc_second", second, m_t % 60);
            check("cyc_blink", blink, m_blink);
            check("cyc_sec_tick", sec_tick, m_tick);
        end
    end

    task automatic press(input logic [3:0] k);
        key_pulse = k;
        @(negedge clk);
        key_pulse = 4'b0;
    endtask

    task automatic wait_tick(input string name, input int exp_cycles);
        int n;
        n = 1;
        @(negedge clk);
        while (sec_tick !== 1'b1 && n < 25) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    task automatic wait_blink_low();
        int n;
        n = 0;
        while (blink !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("blink_low_reached", blink, 0);
    endtask

    task automatic check_time(input string name, input int h, input int mi, input int s);
        check({name, "_h"}, hour, h);
        check({name, "_m"}, minute, mi);
        check({name, "_s"}, second, s);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_mode"}, mode, 0);
        check_time(name, 0, 0, 0);
        check({name, "_blink"}, blink, 1);
        check({name, "_tick"}, sec_tick, 0);
    endtask

    logic [8:0] bpat = 9'b1_0000_1111;
    logic [4:0] rpat = 5'b0_1111;
    logic [1:0] mpat [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        cmp_en = 1'b1;

        press(K_MODE);
        check("enter_set_h", mode, 1);
        for (int i = 0; i < 9; i++) begin
            check("blink_pattern", blink, bpat[i]);
            if (i < 8) @(negedge clk);
        end

        press(K_DEC);
        check("hour_dec_wrap", hour, 23);
        press(K_INC);
        check("hour_inc_wrap", hour, 0);
        check("hour_inc_no_carry", minute, 0);

        wait_blink_low();
        press(K_INC);
        check("inc_hour_to_1", hour, 1);
        check("inc_forces_blink", blink, 1);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("blink_restart", blink, rpat[i]);
        end
        press(K_DEC);
        press(K_DEC);
        check("hour_back_to_23", hour, 23);

        press(K_MODE);
        check("enter_set_m", mode, 2);
        press(K_DEC);
        check("min_dec_wrap", minute, 59);
        check("min_dec_no_borrow", hour, 23);

        press(K_MODE);
        check("enter_set_s", mode, 3);
        press(K_DEC);
        press(K_INC);
        check("sec_inc_wrap", second, 0);
        check("sec_inc_no_carry", minute, 59);
        press(4'b0110);
        check("inc_over_dec", second, 1);
        press(K_CLR);
        check("sec_clr", second, 0);
        press(K_DEC);
        press(K_DEC);
        check_time("set_235958", 23, 59, 58);
        press(4'b0011);
        check("mode_over_inc", mode, 0);
        check("mode_over_inc_sec", second, 58);

        wait_tick("first_tick_latency", 10);
        check_time("t_235959", 23, 59, 59);
        wait_tick("second_tick_latency", 10);
        check_time("t_000000", 0, 0, 0);
        check("run_mode", mode, 0);
        check("run_blink", blink, 1);

        for (int i = 0; i < 4; i++) begin
            press(K_MODE);
            check("mode_cycle", mode, mpat[i]);
            if (i < 3) repeat (2) @(negedge clk);
        end
        wait_tick("tick_after_mode_cycle", 10);
        check_time("t_000001", 0, 0, 1);

        repeat (9) @(negedge clk);
        press(K_CLR);
        check("clr_on_wrap_sec", second, 0);
        check("clr_on_wrap_tick", sec_tick, 0);
        wait_tick("tick_after_clr", 10);
        check_time("after_clr", 0, 0, 1);

        press(K_MODE);
        repeat (12) press(K_INC);
        press(K_MODE);
        repeat (26) press(K_DEC);
        press(K_MODE);
        repeat (5) press(K_DEC);
        press(K_MODE);
        press(K_MODE);
        press(K_MODE);
        check("pre_reset_mode", mode, 2);
        check_time("t_123456", 12, 34, 56);
        wait_blink_low();

        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        wait_tick("tick_after_reset", 10);
        check_time("after_reset", 0, 0, 1);
        check("after_reset_mode", mode, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1);
    end

endmodule
